// File: rtl/cla_serial_pkg.sv
// Shared types and helpers for the nibble-serial CLA adder.
// Holds the FSM state enum, the nibble width and the index-width helper.
package cla_serial_pkg;

    // Operation phases of the serial adder
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of one nibble step, matching the 4-bit cla
    localparam int NIB_W = 4;

    // Index register width; never below one bit so a
    // single-nibble build still has a legal vector.
    function automatic int idx_width(input int nibs);
        if (nibs <= 1) begin
            return 1;
        end
        return $clog2(nibs);
    endfunction

endpackage

// File: rtl/cla.sv
// 4-bit carry-lookahead adder, the existing building block.
// Ports: a, b (4b operands), c_in, s (4b sum), c_out.
module cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = a ^ b;
    assign g = a & b;

    // Every carry is expanded directly from c_in, not rippled
    assign c[0] = c_in;
    assign c[1] = g[0]
                | (p[0] & c_in);
    assign c[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & c_in);
    assign c[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_in);
    assign c[4] = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c_in);

    assign s     = p ^ c[3:0];
    assign c_out = c[4];

endmodule

// File: rtl/cla_serial_adder.sv
// Multi-cycle WIDTH-bit adder driving one 4-bit cla a nibble per clock.
// Ports: clk, rst (sync, active-high), start, a, b, c_in,
//        [sub when CLA_SERIAL_SUB_EN], busy, done, sum, c_out.
// Optional macro CLA_SERIAL_SUB_EN adds the sub port (a - b).
module cla_serial_adder
    import cla_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef CLA_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int NIBS = WIDTH / NIB_W;
    localparam int IW   = idx_width(NIBS);

    localparam logic [IW-1:0] LAST = IW'(NIBS - 1);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             inv;

    logic [NIB_W-1:0] a_nib;
    logic [NIB_W-1:0] b_nib;
    logic [NIB_W-1:0] b_in;
    logic [NIB_W-1:0] cla_s;
    logic             cla_c;

`ifdef CLA_SERIAL_SUB_EN
    logic sub_reg;

    assign inv = sub_reg;
`else
    assign inv = 1'b0;
`endif

    // Select the current nibble of each latched operand
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBS; i++) begin
            if (idx == IW'(i)) begin
                a_nib = a_reg[i*NIB_W +: NIB_W];
                b_nib = b_reg[i*NIB_W +: NIB_W];
            end
        end
    end

    // Subtraction adds the one's complement of b plus one
    assign b_in = b_nib ^ {NIB_W{inv}};

    cla u_cla (
        .a     (a_nib),
        .b     (b_in),
        .c_in  (carry),
        .s     (cla_s),
        .c_out (cla_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            idx   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
`ifdef CLA_SERIAL_SUB_EN
            sub_reg <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        idx   <= '0;
                        sum   <= '0;
                        c_out <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef CLA_SERIAL_SUB_EN
                        sub_reg <= sub;
                        // The +1 of two's complement enters as carry
                        carry   <= sub | c_in;
`else
                        carry   <= c_in;
`endif
                    end
                end

                RUN: begin
                    for (int i = 0; i < NIBS; i++) begin
                        if (idx == IW'(i)) begin
                            sum[i*NIB_W +: NIB_W] <= cla_s;
                        end
                    end
                    carry <= cla_c;
                    if (idx == LAST) begin
                        idx   <= '0;
                        c_out <= cla_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_serial_adder.sv
// Self-checking bench for cla_serial_adder (WIDTH=16).
// Random and directed operations against an arithmetic reference.
module tb_cla_serial_adder;

    localparam int W    = 16;
    localparam int NIBS = W / 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;

    int total;
    int bad;

    cla_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
`ifdef CLA_SERIAL_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: {carry, sum} of plain modulo-2^W arithmetic
    function automatic logic [W:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic ci,
                                         input logic s);
        logic [W:0] r;
        if (s) begin
            r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        end else begin
            r = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
        end
        return r;
    endfunction

    // One operation; poke drives junk starts during RUN and DONE
    task automatic do_op(input logic [W-1:0] x,
                         input logic [W-1:0] y,
                         input logic ci,
                         input logic s,
                         input bit poke);
        logic [W:0] exp;
        int n;
        int nb;
        int both;
        exp = model(x, y, ci, s);
        @(negedge clk);
        a = x; b = y; c_in = ci; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0; nb = 0; both = 0;
        while (!done && n < 40) begin
            if (busy) nb++;
            if (busy && done) both++;
            // Operands may change freely after acceptance
            a = W'($urandom); b = W'($urandom);
            c_in = 1'($urandom); sub = 1'($urandom);
            if (poke) start = (n == 1);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("latency", n, NIBS);
        check("busy_cycles", nb, NIBS);
        check("busy_and_done", both, 0);
        check("busy_at_done", busy, 1'b0);
        check("sum", sum, exp[W-1:0]);
        check("c_out", c_out, exp[W]);
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", done, 1'b0);
        check("idle_after", busy, 1'b0);
        check("sum_hold", sum, exp[W-1:0]);
        check("c_out_hold", c_out, exp[W]);
    endtask

    task automatic reset_abort();
        @(negedge clk);
        a = 16'h5555; b = 16'h3333; c_in = 1'b1;
        sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sum", sum, 16'h0);
        check("rst_cout", c_out, 1'b0);
        // rst still high with start: start must lose
        @(negedge clk);
        check("rst_over_start", busy, 1'b0);
        rst = 1'b0;
        start = 1'b0;
        for (int i = 0; i < NIBS + 2; i++) begin
            @(negedge clk);
            check("no_done_after_rst", done, 1'b0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
        sub   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_sum", sum, 16'h0);
        check("reset_cout", c_out, 1'b0);
        rst = 1'b0;

        do_op(16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("tp1_sum", sum, 16'h0001);
        do_op(16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0);
        check("tp2_sum", sum, 16'h0002);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        check("tp3_sum", sum, 16'h0000);
        check("tp3_cout", c_out, 1'b1);
        do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
        check("ripple_sum", sum, 16'h0000);
        check("ripple_cout", c_out, 1'b1);
        do_op(16'hFFB0, 16'h0028, 1'b0, 1'b0, 1'b1);
        check("tp4_sum", sum, 16'hFFD8);
        do_op(16'h7FFF, 16'h8000, 1'b0, 1'b0, 1'b0);

        reset_abort();
        do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
        check("tp5_sum", sum, 16'h2345);

`ifdef CLA_SERIAL_SUB_EN
        do_op(16'h0050, 16'h0028, 1'b0, 1'b1, 1'b0);
        check("sub1_sum", sum, 16'h0028);
        check("sub1_cout", c_out, 1'b1);
        do_op(16'h0028, 16'h0050, 1'b1, 1'b1, 1'b0);
        check("sub2_sum", sum, 16'hFFD8);
        check("sub2_cout", c_out, 1'b0);
`endif

        for (int k = 0; k < 30; k++) begin
            logic s;
`ifdef CLA_SERIAL_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            do_op(W'($urandom), W'($urandom),
                  1'($urandom), s, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
